// File: rtl/load_store_unit_if.sv
// Execute-stage request, memory bus and completion signals of the load/store unit.
// The slave modport is the unit's own view; master is the surrounding pipeline/memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_addr, req_we, req_funct3, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_we, req_funct3, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, byte-lane placement for stores,
// lane extraction plus sign/zero extension for loads, misalignment/illegal-width detection.
module load_store_unit (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [2:0]  funct3_reg;
    logic [1:0]  addr_off_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;

    logic        accept;
    logic        illegal;
    logic [3:0]  be_placed;
    logic [31:0] wdata_placed;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    assign accept = bus.req_valid && (state_reg == IDLE);

    always_comb begin
        illegal = 1'b1;
        case (bus.req_funct3)
            3'b000:         illegal = 1'b0;
            3'b001:         illegal = bus.req_addr[0];
            3'b010:         illegal = (bus.req_addr[1:0] != 2'b00);
            3'b100, 3'b101: illegal = bus.req_we;
            default:        illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   be_placed = 4'b0001 << bus.req_addr[1:0];
            2'b01:   be_placed = 4'b0011 << bus.req_addr[1:0];
            default: be_placed = 4'b1111;
        endcase
    end

    // Each byte lane picks its source byte: own lane for W, low/high half for H, byte 0 for B.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HALF_BYTE = gi % 2;
            assign wdata_placed[8*gi +: 8] =
                (bus.req_funct3[1:0] == 2'b10) ? bus.req_wdata[8*gi +: 8] :
                (bus.req_funct3[1:0] == 2'b01) ? bus.req_wdata[8*HALF_BYTE +: 8] :
                                                 bus.req_wdata[7:0];
        end
    endgenerate

    always_comb begin
        load_shifted = bus.mem_rdata >> {addr_off_reg, 3'b000};
        load_ext     = load_shifted;
        case (funct3_reg)
            3'b000:  load_ext = {{24{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_ext = {24'h000000, load_shifted[7:0]};
            3'b101:  load_ext = {16'h0000,   load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = illegal ? RESP : REQ;
            REQ:  if (bus.mem_gnt) state_next = WAIT;
            // rvalid alongside gnt is deliberately not honoured: only WAIT takes the response.
            WAIT: if (bus.mem_rvalid) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_reg    <= 3'b000;
            addr_off_reg  <= 2'b00;
            err_reg       <= 1'b0;
            rdata_reg     <= 32'h0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_be_reg    <= 4'h0;
            mem_wdata_reg <= 32'h0;
        end else begin
            if (accept) begin
                funct3_reg   <= bus.req_funct3;
                addr_off_reg <= bus.req_addr[1:0];
                err_reg      <= illegal;
                rdata_reg    <= 32'h0;
                // Bus fields only change on a legal accept so a rejected op never disturbs them.
                if (!illegal) begin
                    mem_we_reg    <= bus.req_we;
                    mem_addr_reg  <= {bus.req_addr[31:2], 2'b00};
                    mem_be_reg    <= be_placed;
                    mem_wdata_reg <= wdata_placed;
                end
            end
            if ((state_reg == WAIT) && bus.mem_rvalid && !mem_we_reg) begin
                rdata_reg <= load_ext;
            end
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_req   = (state_reg == REQ);
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_err   = (state_reg == RESP) && err_reg;
    assign bus.rsp_rdata = (state_reg == RESP) ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: the driver pushes expected bus
// and completion records, a forked monitor compares them as the DUT presents them.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   txn_id = 0;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at_cyc;
    } rsp_exp_t;

    mem_exp_t mq[$];
    rsp_exp_t rq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:       return 1'b1;
            3'd1:       return (addr % 2) == 0;
            3'd2:       return (addr % 4) == 0;
            3'd4, 3'd5: return !we;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = ref_size(f3);
        int v;
        if (sz == 4) return 4'hF;
        v = ((1 << sz) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        int sz = ref_size(f3);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int          sz = ref_size(f3);
        logic [31:0] sh = word >> (8 * (addr % 4));
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return sh;
        mask = (32'd1 << (8 * sz)) - 1;
        v = sh & mask;
        if (f3 < 3'd4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        return v;
    endfunction

    // ---------------- monitor ----------------
    task automatic monitor();
        mem_exp_t m;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                check("req_ready_busy", {31'b0, bus.req_ready}, 32'h0);
                if (mq.size() == 0) begin
                    check("unexpected_mem_req", 32'h1, 32'h0);
                end else begin
                    m = mq[0];
                    check("mem_addr",  bus.mem_addr, m.addr);
                    check("mem_be",    {28'b0, bus.mem_be}, {28'b0, m.be});
                    check("mem_we",    {31'b0, bus.mem_we}, {31'b0, m.we});
                    if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
                    if (bus.mem_gnt) void'(mq.pop_front());
                end
            end
            if (bus.rsp_valid) begin
                check("req_ready_resp", {31'b0, bus.req_ready}, 32'h0);
                if (rq.size() == 0) begin
                    check("unexpected_rsp_valid", 32'h1, 32'h0);
                end else begin
                    r = rq.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, r.rdata);
                    check("rsp_err",   {31'b0, bus.rsp_err}, {31'b0, r.err});
                    check("rsp_cycle", cyc, r.at_cyc);
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'h1);
    endtask

    // Called at #1 after a rising edge; returns at the same phase with the DUT idle.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [2:0] f3,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gd, input int rd);
        int       acc;
        bit       ok;
        mem_exp_t m;
        rsp_exp_t r;
        wait_ready();
        ok = ref_legal(we, f3, addr);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_wdata  = wdata;
        acc = cyc;
        if (ok) begin
            m.addr = addr & 32'hFFFF_FFFC;
            m.be = ref_be(f3, addr);
            m.we = we;
            m.wdata = ref_wdata(f3, wdata);
            mq.push_back(m);
            r.rdata = we ? 32'h0 : ref_load(f3, addr, rdata);
            r.err = 1'b0;
            r.at_cyc = acc + 3 + gd + rd;
        end else begin
            r.rdata = 32'h0;
            r.err = 1'b1;
            r.at_cyc = acc + 1;
        end
        rq.push_back(r);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        if (ok) begin
            for (int i = 0; i < gd; i++) begin
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'($urandom % 2);
                bus.mem_rdata  = $urandom;
                @(posedge clk); #1;
            end
            bus.mem_gnt    = 1'b1;
            bus.mem_rvalid = 1'($urandom % 2);
            bus.mem_rdata  = ~rdata;
            @(posedge clk); #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            for (int i = 0; i < rd; i++) begin
                bus.mem_gnt   = 1'($urandom % 2);
                bus.mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
        end
        @(posedge clk); #1;
        $display("[TB] txn %0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h gnt_dly=%0d rv_dly=%0d legal=%0d",
                 txn_id, we, f3, addr, wdata, rdata, gd, rd, ok);
        txn_id++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'h1);
        check({tag, "_mem_req"},   {31'b0, bus.mem_req},   32'h0);
        check({tag, "_mem_we"},    {31'b0, bus.mem_we},    32'h0);
        check({tag, "_mem_addr"},  bus.mem_addr,           32'h0);
        check({tag, "_mem_be"},    {28'b0, bus.mem_be},    32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,          32'h0);
        check({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata,          32'h0);
        check({tag, "_rsp_err"},   {31'b0, bus.rsp_err},   32'h0);
    endtask

    // Legal load accepted, granted at once, then reset pulsed while waiting for rvalid.
    task automatic reset_in_wait();
        mem_exp_t m;
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_3004;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'h0;
        m.addr = 32'h0000_3004;
        m.be = 4'hF;
        m.we = 1'b0;
        m.wdata = 32'h0;
        mq.push_back(m);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("[TB] txn %0d reset pulsed in WAIT, late rvalid ignored", txn_id);
        txn_id++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3_tab [8];
        logic [2:0]  f3;
        logic [31:0] addr;
        int          sz;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

        bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_we = 1'b0;
        bus.req_funct3 = 3'b0; bus.req_wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        fork
            monitor();
        join_none

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        check_reset_outputs("reset_hold");
        #1 rst_n = 1'b1;

        // Directed cases
        do_txn(32'h0000_1003, 1'b0, 3'b000, 32'h0,         32'h80FF_1234, 0, 0); // LB
        do_txn(32'h0000_2002, 1'b0, 3'b101, 32'h0,         32'h9ABC_0000, 0, 0); // LHU
        do_txn(32'h0000_2002, 1'b0, 3'b001, 32'h0,         32'h9ABC_0000, 0, 0); // LH
        do_txn(32'h0000_0011, 1'b1, 3'b000, 32'hDEAD_BEEF, 32'h0,         0, 0); // SB
        do_txn(32'h0000_0102, 1'b0, 3'b010, 32'h0,         32'h0,         0, 0); // misaligned LW
        do_txn(32'h0000_0100, 1'b0, 3'b011, 32'h0,         32'h0,         0, 0); // illegal funct3
        do_txn(32'h0000_0040, 1'b1, 3'b100, 32'h1234_5678, 32'h0,         0, 0); // store BU
        do_txn(32'h0000_0402, 1'b1, 3'b001, 32'h0000_A5C3, 32'h0,         5, 0); // SH, gnt stall
        do_txn(32'h0000_0800, 1'b0, 3'b010, 32'h0,         32'h1357_9BDF, 5, 4); // LW, stall + late rvalid
        reset_in_wait();
        do_txn(32'h0000_0C01, 1'b0, 3'b100, 32'h0,         32'h0000_F200, 1, 2); // LBU after reset

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            f3 = f3_tab[$urandom_range(0, 7)];
            addr = $urandom;
            sz = ref_size(f3);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            do_txn(addr, 1'($urandom % 2), f3, $urandom, $urandom,
                   $urandom_range(0, 5), $urandom_range(0, 4));
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mem_queue_drained", mq.size(), 32'h0);
        check("rsp_queue_drained", rq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
